// File: rtl/trace_event_capture_if.sv
// Push/full handshake between the trace event capture stage and the tracer FIFO.
interface trace_event_capture_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] fifo_d;
  logic                 fifo_push;
  logic                 fifo_full;

  modport master (output fifo_d, output fifo_push, input fifo_full);
  modport slave  (input fifo_d, input fifo_push, output fifo_full);
endinterface

// File: rtl/trace_event_capture.sv
// Timestamps probe-vector changes and pushes packed records into the tracer FIFO,
// absorbing back-pressure with a one-entry output register and counting drops.
module trace_event_capture #(
  parameter int NumProbes = 8,
  parameter int TsWidth   = 22,
  parameter int CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NumProbes-1:0] probes,
  trace_event_capture_if.master fifo,
  output logic [CntWidth-1:0]  drop_count,
  output logic                 busy
);

  localparam int RecWidth = 2 + TsWidth + NumProbes;

  logic [TsWidth-1:0]   r_ts;
  logic [NumProbes-1:0] r_prev_probes;
  logic                 r_out_valid;
  logic [RecWidth-1:0]  r_out_data;
  logic                 r_ovf_pending;
  logic                 r_wrap_pending;
  logic [CntWidth-1:0]  r_drop_count;

  logic w_change;
  logic w_accept;
  logic w_free;
  logic w_req;
  logic w_load;
  logic w_drop;
  logic w_wrap_set;

  always_comb begin
    w_change   = (probes != r_prev_probes);
    w_accept   = r_out_valid & ~fifo.fifo_full;
    w_free     = ~r_out_valid | w_accept;
    w_req      = enable & (w_change | r_wrap_pending | r_ovf_pending);
    w_load     = w_req & w_free;
    w_drop     = enable & w_change & ~w_free;
    w_wrap_set = enable & (r_ts == '1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts          <= '0;
      r_prev_probes <= '0;
    end else begin
      r_ts          <= enable ? r_ts + TsWidth'(1) : '0;
      r_prev_probes <= probes;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {r_wrap_pending, r_ovf_pending, r_ts, probes};
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // A wrap landing on the same edge as a load must survive for the next record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap_pending <= 1'b0;
    end else if (!enable) begin
      r_wrap_pending <= 1'b0;
    end else if (w_wrap_set) begin
      r_wrap_pending <= 1'b1;
    end else if (w_load) begin
      r_wrap_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf_pending <= 1'b0;
      r_drop_count  <= '0;
    end else if (w_drop) begin
      r_ovf_pending <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + CntWidth'(1);
      end
    end else if (w_load) begin
      r_ovf_pending <= 1'b0;
    end
  end

  assign fifo.fifo_d    = r_out_data;
  assign fifo.fifo_push = r_out_valid;
  assign drop_count     = r_drop_count;
  assign busy           = r_out_valid | r_ovf_pending | r_wrap_pending;

endmodule
